// File: rtl/symbol_aligner_rx_pkg.sv
// ---------------------------------------------------------------------------
// symbol_aligner_rx_pkg
// Shared definitions for the receive-side comma aligner:
//   - K28.5 comma codes for both running disparities (the transmitter's
//     encoder uses the same values)
//   - aligner FSM state encoding
//   - the comma comparator used by the detector
// No ports (package).
// ---------------------------------------------------------------------------
package symbol_aligner_rx_pkg;

  // K28.5 as it appears in the shift register, bit 0 = first bit received.
  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  // Highest bit position inside a 10-bit symbol.
  localparam logic [3:0] LAST_BIT = 4'd9;

  // HUNT:   searching for a comma at any bit position
  // VERIFY: a candidate phase is being confirmed by further aligned commas
  // LOCKED: symbol boundaries are trusted and symbols are emitted
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } alignState_t;

  // True when a 10-bit window holds K28.5 in either running disparity.
  function automatic logic isK28p5(input logic [9:0] sym);
    return (sym == K28_5_RDN) || (sym == K28_5_RDP);
  endfunction

endpackage

// File: rtl/symbol_aligner_rx_comma_detector.sv
// ---------------------------------------------------------------------------
// symbol_aligner_rx_comma_detector
// 10-bit receive shift register plus the K28.5 comparators. Bits arrive
// LSB first, so the newest bit enters at the top and the oldest bit of the
// current window sits in bit 0.
// Ports:
//   i_clk        receive bit clock
//   i_rst_n      asynchronous active-low reset
//   i_enb        bit enable; the register holds while low
//   i_serialIn   serial data bit
//   o_sh         current 10-bit window (registered)
//   o_commaHit   window equals K28.5 (RD- or RD+), decoded from o_sh
// ---------------------------------------------------------------------------
module symbol_aligner_rx_comma_detector
  import symbol_aligner_rx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enb,
  input  logic       i_serialIn,
  output logic [9:0] o_sh,
  output logic       o_commaHit
);

  logic [9:0] r_sh;

  // Shift the new bit in from the top so that after ten bits the first
  // received bit ('a') lands in bit 0, matching the decoder's {j..a} order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh <= '0;
    end else if (i_enb) begin
      r_sh <= {i_serialIn, r_sh[9:1]};
    end
  end

  // The comparison is taken on the registered window, so a comma becomes
  // visible the cycle after its last bit was sampled.
  assign o_sh       = r_sh;
  assign o_commaHit = isK28p5(r_sh);

endmodule

// File: rtl/symbol_aligner_rx.sv
// ---------------------------------------------------------------------------
// symbol_aligner_rx
// Receive-side comma aligner and deserializer for the 8b/10b serial link.
// Hunts for K28.5, locks the symbol phase after LOCK_CNT aligned commas and
// then emits one aligned 10-bit symbol every ten enabled bit times. Lock is
// dropped after UNLOCK_CNT consecutive misaligned commas.
// Parameters:
//   LOCK_CNT     aligned commas (including the first) needed to lock, >= 1
//   UNLOCK_CNT   consecutive misaligned commas that force a re-hunt, >= 1
// Ports:
//   i_clk        receive bit clock, all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_enb        bit enable; low freezes everything and suppresses strobes
//   i_serialIn   serial bit stream, LSB ('a') first
//   o_symOut     last aligned symbol {j..a}, held between strobes
//   o_symValid   one-cycle strobe: o_symOut holds a new symbol
//   o_commaOut   qualifies o_symValid: the symbol is K28.5
//   o_locked     high while the aligner is LOCKED
//   o_alignErr   one-cycle pulse: misaligned comma seen while LOCKED
// ---------------------------------------------------------------------------
module symbol_aligner_rx
  import symbol_aligner_rx_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enb,
  input  logic       i_serialIn,
  output logic [9:0] o_symOut,
  output logic       o_symValid,
  output logic       o_commaOut,
  output logic       o_locked,
  output logic       o_alignErr
);

  // Counters are just wide enough to reach their target value.
  localparam int MATCH_W = $clog2(LOCK_CNT) + 1;
  localparam int MISS_W  = $clog2(UNLOCK_CNT) + 1;

  localparam logic [MATCH_W-1:0] MATCH_TGT = MATCH_W'(LOCK_CNT);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
  localparam logic [MISS_W-1:0]  MISS_TGT  = MISS_W'(UNLOCK_CNT);
  localparam logic [MISS_W-1:0]  MISS_ONE  = MISS_W'(1);

  alignState_t        r_state;
  alignState_t        w_stateNext;
  logic [3:0]         r_bitCnt;
  logic [3:0]         w_bitCntNext;
  logic [MATCH_W-1:0] r_matchCnt;
  logic [MATCH_W-1:0] w_matchCntNext;
  logic [MISS_W-1:0]  r_missCnt;
  logic [MISS_W-1:0]  w_missCntNext;
  logic [9:0]         r_symOut;
  logic [9:0]         w_symOutNext;
  logic               r_symValid;
  logic               w_symValidNext;
  logic               r_commaOut;
  logic               w_commaOutNext;
  logic               r_alignErr;
  logic               w_alignErrNext;

  logic [9:0]         w_sh;
  logic               w_commaHit;
  logic               w_boundary;
  logic               w_misaligned;
  logic [3:0]         w_bitCntStep;
  logic [MATCH_W-1:0] w_matchInc;
  logic [MISS_W-1:0]  w_missInc;

  symbol_aligner_rx_comma_detector u_commaDetector (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enb      (i_enb),
    .i_serialIn (i_serialIn),
    .o_sh       (w_sh),
    .o_commaHit (w_commaHit)
  );

  // Bit position 0 marks the cycle where the window holds one whole symbol
  // at the current phase; a comma anywhere else is misaligned.
  assign w_boundary   = i_enb & (r_bitCnt == 4'd0);
  assign w_misaligned = i_enb & w_commaHit & (r_bitCnt != 4'd0);
  assign w_bitCntStep = (r_bitCnt == LAST_BIT) ? 4'd0 : r_bitCnt + 4'd1;

  // Saturating increments so the counters can never wrap back to a low
  // value and fake a fresh start.
  assign w_matchInc = (r_matchCnt >= MATCH_TGT) ? MATCH_TGT : r_matchCnt + MATCH_ONE;
  assign w_missInc  = (r_missCnt >= MISS_TGT) ? MISS_TGT : r_missCnt + MISS_ONE;

  // State, counters and output registers. Pulses are rebuilt every cycle
  // by the next-state logic, so they fall back to 0 on their own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_HUNT;
      r_bitCnt   <= 4'd0;
      r_matchCnt <= '0;
      r_missCnt  <= '0;
      r_symOut   <= '0;
      r_symValid <= 1'b0;
      r_commaOut <= 1'b0;
      r_alignErr <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_bitCnt   <= w_bitCntNext;
      r_matchCnt <= w_matchCntNext;
      r_missCnt  <= w_missCntNext;
      r_symOut   <= w_symOutNext;
      r_symValid <= w_symValidNext;
      r_commaOut <= w_commaOutNext;
      r_alignErr <= w_alignErrNext;
    end
  end

  // Next-state logic. With the enable low everything holds and no pulse
  // is produced. A comma that realigns the phase turns the current cycle
  // into a boundary, hence the bit counter restarts at 1 rather than 0.
  always_comb begin
    w_stateNext    = r_state;
    w_bitCntNext   = r_bitCnt;
    w_matchCntNext = r_matchCnt;
    w_missCntNext  = r_missCnt;
    w_symOutNext   = r_symOut;
    w_symValidNext = 1'b0;
    w_commaOutNext = 1'b0;
    w_alignErrNext = 1'b0;

    if (i_enb) begin
      w_bitCntNext = w_bitCntStep;

      unique case (r_state)
        ST_HUNT: begin
          if (w_commaHit) begin
            w_bitCntNext   = 4'd1;
            w_matchCntNext = MATCH_ONE;
            if (LOCK_CNT == 1) begin
              w_stateNext   = ST_LOCKED;
              w_missCntNext = '0;
            end else begin
              w_stateNext = ST_VERIFY;
            end
          end
        end

        ST_VERIFY: begin
          if (w_boundary && w_commaHit) begin
            w_matchCntNext = w_matchInc;
            if (w_matchInc == MATCH_TGT) begin
              w_stateNext   = ST_LOCKED;
              w_missCntNext = '0;
            end
          end else if (w_misaligned) begin
            // The candidate phase was wrong; start confirming the new one.
            w_bitCntNext   = 4'd1;
            w_matchCntNext = MATCH_ONE;
          end
        end

        ST_LOCKED: begin
          if (w_boundary) begin
            w_symOutNext   = w_sh;
            w_symValidNext = 1'b1;
            w_commaOutNext = w_commaHit;
            if (w_commaHit) begin
              w_missCntNext = '0;
            end
          end else if (w_misaligned) begin
            // Keep the old phase until enough consecutive misses pile up.
            w_alignErrNext = 1'b1;
            if (w_missInc == MISS_TGT) begin
              w_stateNext    = ST_HUNT;
              w_matchCntNext = '0;
              w_missCntNext  = '0;
            end else begin
              w_missCntNext = w_missInc;
            end
          end
        end

        default: begin
          w_stateNext = ST_HUNT;
        end
      endcase
    end
  end

  assign o_symOut   = r_symOut;
  assign o_symValid = r_symValid;
  assign o_commaOut = r_commaOut;
  assign o_alignErr = r_alignErr;
  assign o_locked   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_symbol_aligner_rx.sv
// ---------------------------------------------------------------------------
// tb_symbol_aligner_rx
// Drives the comma aligner with directed symbol tables, hand-written corner
// sequences (bit slip, stall, VERIFY restart, async reset) and a random
// stream, comparing every cycle against a bit-history reference model.
// ---------------------------------------------------------------------------
module tb_symbol_aligner_rx;

  localparam int LOCK_CNT   = 3;
  localparam int UNLOCK_CNT = 4;
  localparam logic [9:0] C_RDN = 10'h17C;
  localparam logic [9:0] C_RDP = 10'h283;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enb;
  logic       serialIn;
  logic [9:0] symOut;
  logic       symValid;
  logic       commaOut;
  logic       locked;
  logic       alignErr;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: the raw received bit history, how many enabled
  // bits have arrived, and the bit count at which the trusted phase began.
  bit         mHist[$];
  int         mN;
  int         mAnchor;
  int         mMatches;
  int         mMisses;
  logic       mLocked;
  logic [9:0] eSym;
  logic       eValid;
  logic       eComma;
  logic       eErr;

  logic [13:0] lastOut;
  int          errSeen;

  typedef struct {
    logic [9:0]  sym;
    int          stallAt;
    int          stallLen;
    logic [13:0] expFirst;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  symbol_aligner_rx #(
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enb      (enb),
    .i_serialIn (serialIn),
    .o_symOut   (symOut),
    .o_symValid (symValid),
    .o_commaOut (commaOut),
    .o_locked   (locked),
    .o_alignErr (alignErr)
  );

  // Model reset: history of zeros and everything idle.
  task automatic modelReset();
    mHist.delete();
    for (int i = 0; i < 10; i++) mHist.push_back(1'b0);
    mN       = 0;
    mAnchor  = 0;
    mMatches = 0;
    mMisses  = 0;
    mLocked  = 1'b0;
    eSym     = '0;
    eValid   = 1'b0;
    eComma   = 1'b0;
    eErr     = 1'b0;
  endtask

  // The last ten received bits, oldest in bit 0.
  function automatic logic [9:0] modelWindow();
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[i] = mHist[mHist.size() - 10 + i];
    return w;
  endfunction

  // One clock edge of the reference model, evaluated from the rules on
  // window contents and phase distance rather than a bit counter.
  task automatic modelStep(input logic en, input logic b);
    logic [9:0] win;
    logic       hit;
    logic       onPhase;
    eValid = 1'b0;
    eComma = 1'b0;
    eErr   = 1'b0;
    if (en) begin
      win     = modelWindow();
      hit     = (win == C_RDN) || (win == C_RDP);
      onPhase = ((mN - mAnchor) % 10) == 0;
      if (!mLocked && mMatches == 0) begin
        if (hit) begin
          mAnchor  = mN;
          mMatches = 1;
          if (mMatches >= LOCK_CNT) begin
            mLocked = 1'b1;
            mMisses = 0;
          end
        end
      end else if (!mLocked) begin
        if (hit && onPhase) begin
          mMatches++;
          if (mMatches >= LOCK_CNT) begin
            mLocked = 1'b1;
            mMisses = 0;
          end
        end else if (hit) begin
          mAnchor  = mN;
          mMatches = 1;
        end
      end else begin
        if (onPhase) begin
          eSym   = win;
          eValid = 1'b1;
          eComma = hit;
          if (hit) mMisses = 0;
        end else if (hit) begin
          eErr = 1'b1;
          mMisses++;
          if (mMisses >= UNLOCK_CNT) begin
            mLocked  = 1'b0;
            mMatches = 0;
            mMisses  = 0;
          end
        end
      end
      mHist.push_back(b);
      if (mHist.size() > 10) void'(mHist.pop_front());
      mN++;
    end
  endtask

  task automatic checkOutput();
    logic [13:0] act;
    logic [13:0] exp;
    act = {symOut, symValid, commaOut, locked, alignErr};
    exp = {eSym, eValid, eComma, mLocked, eErr};
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL cycleCheck t=%0t actual sym=%h v=%b c=%b l=%b e=%b required sym=%h v=%b c=%b l=%b e=%b",
               $time, symOut, symValid, commaOut, locked, alignErr,
               eSym, eValid, eComma, mLocked, eErr);
    end
  endtask

  task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // One bit time: drive after the falling edge, let the DUT and model take
  // the rising edge, compare on the next falling edge.
  task automatic applyStimulus(input logic en, input logic b);
    enb      = en;
    serialIn = b;
    @(posedge clk);
    modelStep(en, b);
    @(negedge clk);
    checkOutput();
    lastOut = {symOut, symValid, commaOut, locked, alignErr};
    errSeen += int'(alignErr);
  endtask

  // Sends ten bits LSB first with an optional stall before bit stallAt.
  // firstOut captures the outputs right after the symbol's first bit, which
  // is where the boundary of the previous symbol is reported.
  task automatic sendSymbol(input logic [9:0] sym, input int stallAt, input int stallLen,
                            output logic [13:0] firstOut);
    firstOut = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == stallAt) begin
        for (int s = 0; s < stallLen; s++) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      end
      applyStimulus(1'b1, sym[i]);
      if (i == 0) firstOut = lastOut;
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [13:0] fo;
    logic [9:0]  rsym;
    int          r;

    // Directed symbol table: symbol to send and the outputs expected just
    // after its first bit (report of the previous boundary).
    tbl[0]  = '{C_RDN,  -1, 0, {10'h000, 4'b0000}};
    tbl[1]  = '{C_RDN,  -1, 0, {10'h000, 4'b0000}};
    tbl[2]  = '{C_RDN,  -1, 0, {10'h000, 4'b0000}};
    tbl[3]  = '{10'h2AA, -1, 0, {10'h000, 4'b0010}};
    tbl[4]  = '{C_RDN,  -1, 0, {10'h2AA, 4'b1010}};
    tbl[5]  = '{C_RDP,  -1, 0, {C_RDN,   4'b1110}};
    tbl[6]  = '{C_RDN,  -1, 0, {C_RDP,   4'b1110}};
    tbl[7]  = '{C_RDP,  -1, 0, {C_RDN,   4'b1110}};
    tbl[8]  = '{C_RDN,   4, 7, {C_RDP,   4'b1110}};
    tbl[9]  = '{10'h0F0, -1, 0, {C_RDN,   4'b1110}};
    tbl[10] = '{C_RDP,  -1, 0, {10'h0F0, 4'b1010}};
    tbl[11] = '{C_RDN,  -1, 0, {C_RDP,   4'b1110}};

    $display("[TB] reset and idle");
    enb      = 1'b0;
    serialIn = 1'b0;
    rst_n    = 1'b0;
    errSeen  = 0;
    modelReset();
    #100;
    @(negedge clk);
    rst_n = 1'b1;
    checkValue("resetOutputs", {2'b0, symOut, symValid, commaOut, locked, alignErr}, 16'h0);

    r = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 1'b0);
      r += int'(symValid);
    end
    checkValue("idleStrobes", 16'(r), 16'd0);

    $display("[TB] lock and locked stream");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 12; i++) begin
      sendSymbol(tbl[i].sym, tbl[i].stallAt, tbl[i].stallLen, fo);
      checkValue($sformatf("tableRow%0d", i), {2'b0, fo}, {2'b0, tbl[i].expFirst});
    end
    checkValue("lockedStreamErrs", 16'(errSeen), 16'd0);

    $display("[TB] bit slip");
    applyStimulus(1'b1, 1'b0);
    errSeen = 0;
    for (int c = 1; c <= 9; c++) begin
      sendSymbol(C_RDN, -1, 0, fo);
      if (c == 5) begin
        checkValue("slipUnlocked", {15'b0, fo[1]}, 16'd0);
        checkValue("slipErrCount", 16'(errSeen), 16'd4);
      end
      if (c == 7) checkValue("slipStillHunting", {15'b0, fo[1]}, 16'd0);
      if (c == 8) checkValue("slipRelocked", {15'b0, fo[1]}, 16'd1);
      if (c == 9) checkValue("slipNewPhaseSym", {2'b0, fo}, {2'b0, C_RDN, 4'b1110});
    end
    checkValue("slipErrTotal", 16'(errSeen), 16'd4);

    $display("[TB] async reset while locked");
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("asyncResetLocked", {15'b0, locked}, 16'd0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput();

    $display("[TB] VERIFY restart on shifted comma");
    sendSymbol(C_RDN, -1, 0, fo);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    sendSymbol(C_RDN, -1, 0, fo);
    sendSymbol(C_RDN, -1, 0, fo);
    checkValue("verifyRestartC3", {2'b0, fo}, 16'h0);
    sendSymbol(C_RDN, -1, 0, fo);
    checkValue("verifyRestartC4", {2'b0, fo}, 16'h0);
    sendSymbol(10'h2AA, -1, 0, fo);
    checkValue("verifyRestartLock", {2'b0, fo}, {2'b0, 10'h000, 4'b0010});
    sendSymbol(C_RDN, -1, 0, fo);
    checkValue("verifyRestartSym", {2'b0, fo}, {2'b0, 10'h2AA, 4'b1010});

    $display("[TB] random stream");
    for (int s = 0; s < 60; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        rsym = ($urandom_range(0, 1) == 0) ? C_RDN : C_RDP;
      end else begin
        rsym = 10'($urandom);
      end
      if (r == 4) begin
        for (int k = 0; k < int'($urandom_range(1, 9)); k++) applyStimulus(1'b1, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 7) == 0) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        applyStimulus(1'b1, rsym[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
